// File: rtl/arb_req_agent.sv
// Requester front end for the shared fixed-priority arbiter: buffers client beats, requests once a full
// packet is held, streams it under lock, then idles one cycle. Optional head timeout: ARB_REQ_AGENT_TIMEOUT_EN.
module arb_req_agent #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              bus_lock,
  output logic              err_timeout,
  output logic [2:0]        dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a client beat transfers when cmd_valid & cmd_ready; a bus beat transfers whenever
  // bus_valid is high (grant is already folded in), with no back-pressure from the bus side.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_GAP
`ifdef ARB_REQ_AGENT_TIMEOUT_EN
    , S_FLUSH
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [DATA_W:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic            req_q, req_d;
  logic            push, pop, full, head_last, flush_done;
  logic [DATA_W:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[DATA_W];
  assign bus_data  = head[DATA_W-1:0];
  assign bus_last  = head_last;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  // A pop in this cycle frees a slot, so a full buffer can still take a beat.
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready;
  assign req       = req_q;
  assign dbg_state = state_q;
  assign err_timeout = flush_done;

`ifdef ARB_REQ_AGENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  always_comb begin
    tmo_d = '0;
    if (state_q == S_REQ && !grant) tmo_d = tmo_q + TW'(1);
  end

  assign tmo_hit = (state_q == S_REQ) && !grant && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    bus_valid  = 1'b0;
    bus_lock   = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE: if (pkt_cnt_q != '0) state_d = S_REQ;
      S_REQ: begin
        if (grant) begin
          bus_valid = 1'b1;
          pop       = 1'b1;
          state_d   = head_last ? S_GAP : S_XFER;
        end
`ifdef ARB_REQ_AGENT_TIMEOUT_EN
        else if (tmo_hit) state_d = S_FLUSH;
`endif
      end
      S_XFER: begin
        bus_lock = 1'b1;
        if (grant) begin
          bus_valid = 1'b1;
          pop       = 1'b1;
          if (head_last) state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_IDLE;
`ifdef ARB_REQ_AGENT_TIMEOUT_EN
      // The whole head packet is buffered, so draining it never underflows.
      S_FLUSH: begin
        pop = 1'b1;
        if (head_last) begin
          flush_done = 1'b1;
          state_d    = S_GAP;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ) || (state_d == S_XFER);
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_last, cmd_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({push && cmd_last, pop && head_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      req_q     <= req_d;
    end
  end
endmodule

// File: doc/arb_req_agent.md
# arb_req_agent

Requester-side front end for the shared fixed-priority bus arbiter. Buffers outgoing packet beats from a local client, raises this client's request line to the arbiter once a complete packet is held, and streams the packet onto the shared bus while granted. It holds the request and asserts a lock for the whole packet. It then releases the bus for one mandatory idle cycle so lower-priority requesters can win.

## Interface
- DATA_W, 32, bus data width
- FIFO_DEPTH, 8, beat buffer depth; power of two, ≥2; max packet length in beats
- TIMEOUT, 255, cycles in REQ without grant before the head packet is discarded (only with macro)

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  client beat valid
- cmd_ready  out  1  beat accepted when cmd_valid & cmd_ready
- cmd_data  in  DATA_W  beat payload
- cmd_last  in  1  final beat of packet
- req  out  1  request to arbiter (registered)
- grant  in  1  this client's grant bit from arbiter (combinational from req allowed)
- bus_valid  out  1  beat on bus this cycle
- bus_data  out  DATA_W  beat payload (FIFO head)
- bus_last  out  1  final beat marker
- bus_lock  out  1  ownership held; arbiter wrapper must keep grant while high
- err_timeout  out  1  one-cycle pulse, head packet discarded

## Operation
- Beat FIFO, FIFO_DEPTH entries of {data,last}; cmd_ready = !full; push and pop in the same cycle allowed, including when full (pop frees slot in the same cycle: cmd_ready = !full | pop).
- pkt_cnt: number of complete packets (last beats) in FIFO; +1 on push of last, −1 on pop of last, both → unchanged.
- FSM states: IDLE, REQ, XFER, GAP, FLUSH (FLUSH only with macro).
  - IDLE: req=0. pkt_cnt>0 → REQ.
  - REQ: req=1, lock=0. grant=1 → bus_valid=1, pop head; if head last → GAP, else → XFER.
  - XFER: req=1, lock=1. bus_valid = grant; pop per valid beat; pop of last → GAP. Grant drop mid-packet: pause (bus_valid=0), hold req/lock, resume when grant returns; no beat lost or repeated.
  - GAP: req=0, lock=0, exactly one cycle → IDLE.
- bus_data/bus_last = FIFO head; meaningful only when bus_valid=1.
- Packets longer than FIFO_DEPTH are illegal (client guarantees); behaviour undefined.

## Timing
- Reset (rst_n=0 at edge): FSM=IDLE, FIFO empty, pkt_cnt=0, req=0, bus_valid=0, bus_lock=0, err_timeout=0, cmd_ready=1.
- Reset mid-packet discards all buffered beats; outputs at reset values the cycle after the reset edge.
- Latency: last beat accepted at cycle N → req=1 at N+2 (pkt_cnt updates at N+1, REQ entered at N+2); first beat on bus the same cycle grant is seen in REQ.
- Back-to-back packets: min one GAP cycle plus one IDLE cycle between the last beat and the next req assertion.
- Beat pushed in the same cycle as a pop from an empty-but-for-head FIFO is not visible at head until the next cycle (no fall-through).

## Configuration
- ARB_REQ_AGENT_TIMEOUT_EN defined: counter ($clog2(TIMEOUT+1) bits) clears on REQ entry, increments each REQ cycle with grant=0; reaching TIMEOUT → FLUSH (req=0, bus_valid=0, pop one beat/cycle until last popped, err_timeout=1 in that cycle) → GAP. XFER never times out.
- Undefined: no counter, no FLUSH state, REQ waits indefinitely, err_timeout tied 0.

## Test plan
- Single 3-beat packet (A,B,C), grant tied 1 → req rises 2 cycles after C accepted; bus_valid for 3 consecutive cycles with data A,B,C, bus_last on C, bus_lock high on B,C; req=0 for one cycle after.
- Grant low 2 cycles mid-packet of 4 beats → bus_valid gaps 2 cycles, req/bus_lock held, all 4 beats delivered in order exactly once.
- Fill FIFO with 8 beats (two 4-beat packets), grant=0 → cmd_ready=0 with 8 buffered; grant=1 → both packets delivered with one GAP+IDLE between, cmd_ready returns 1 the cycle of first pop.
- Reset asserted during XFER of beat 2 of 4 → next cycle req=0, bus_valid=0, bus_lock=0, cmd_ready=1; later packet delivered clean.
- With ARB_REQ_AGENT_TIMEOUT_EN, TIMEOUT=4, grant held 0 → req high 4 cycles, then head 2-beat packet flushed, err_timeout pulses once, no bus_valid; second queued packet then requested normally.
- Without macro, grant 0 for 1000 cycles → req stays high, err_timeout stays 0, packet delivered on later grant.
